// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/mem/writeback and drives mux selects and enables.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    w_next = S_MEMADR;
          (opcode == OP_RTYPE): w_next = S_EXEC;
          (opcode == OP_BEQ):   w_next = S_BEQ;
          (opcode == OP_J):     w_next = S_JUMP;
          (opcode == OP_ADDI):  w_next = S_ADDIEX;
          default:              w_next = S_TRAP;
        endcase
      end
      // a non-memory opcode here means IR was corrupted: trap
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_TRAP;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    state_dbg   = 4'd0;
    // reset gates every output so no write escapes mid-instruction
    if (reset_n) begin
      state_dbg = r_state;
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_TRAP:   illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control FSM.
// Each step checks state_dbg and the full output bundle against constants.
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state_dbg;
  logic [16:0] outs;

  int n_chk;
  int n_pass;

  // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,SA, SB, PS, OP, ILL}
  localparam logic [16:0] O_FGO  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_FST  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_DEC  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_MADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_MRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_MWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_MWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_EXEC = {10'b0000000001, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] O_RWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_BEQ  = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] O_JMP  = {10'b1000000000, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] O_AWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] O_TRAP = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] O_ZERO = 17'd0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_AD  = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  mips_multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                 ALUOp, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [3:0] st, logic [16:0] exp);
    n_chk++;
    assert ({state_dbg, outs} === {st, exp}) n_pass++;
    else $error("FAIL %s state=%0d outs=%b expected state=%0d outs=%b",
                tag, state_dbg, outs, st, exp);
  endtask

  // inputs already set; settle, compare, then advance one clock edge
  task automatic step(string tag, logic [3:0] st, logic [16:0] exp);
    #1;
    chk(tag, st, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    #12;
    chk("in_reset", 4'd0, O_ZERO);
    reset_n = 1'b1;

    // reset aborts R-type in EXEC
    step("r0_fetch", 4'd0, O_FGO);
    step("r0_dec", 4'd1, O_DEC);
    #1;
    chk("r0_exec", 4'd6, O_EXEC);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_exec", 4'd0, O_ZERO);
    @(posedge clk);
    #1;
    chk("rst_held", 4'd0, O_ZERO);
    reset_n = 1'b1;
    step("rel_fetch", 4'd0, O_FGO);

    opcode = OP_LW;
    step("lw_dec", 4'd1, O_DEC);
    step("lw_madr", 4'd2, O_MADR);
    step("lw_mrd", 4'd3, O_MRD);
    step("lw_mwb", 4'd4, O_MWB);

    opcode = OP_R;
    step("r_fetch", 4'd0, O_FGO);
    step("r_dec", 4'd1, O_DEC);
    step("r_exec", 4'd6, O_EXEC);
    step("r_rwb", 4'd7, O_RWB);

    opcode = OP_BEQ;
    step("beq_fetch", 4'd0, O_FGO);
    step("beq_dec", 4'd1, O_DEC);
    step("beq_beq", 4'd8, O_BEQ);

    opcode = OP_J;
    step("j_fetch", 4'd0, O_FGO);
    step("j_dec", 4'd1, O_DEC);
    step("j_jump", 4'd9, O_JMP);

    opcode = OP_AD;
    step("addi_fetch", 4'd0, O_FGO);
    step("addi_dec", 4'd1, O_DEC);
    step("addi_ex", 4'd10, O_MADR);
    step("addi_wb", 4'd11, O_AWB);

    // sw stalls three cycles in MEMWR
    opcode = OP_SW;
    step("sw_fetch", 4'd0, O_FGO);
    step("sw_dec", 4'd1, O_DEC);
    step("sw_madr", 4'd2, O_MADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_stall", 4'd5, O_MWR);
    mem_ready = 1'b1;
    step("sw_done", 4'd5, O_MWR);

    // lw stalls one cycle in MEMRD, opcode noise in FETCH ignored
    opcode = OP_BAD;
    step("lw2_fetch", 4'd0, O_FGO);
    opcode = OP_LW;
    step("lw2_dec", 4'd1, O_DEC);
    step("lw2_madr", 4'd2, O_MADR);
    mem_ready = 1'b0;
    step("lw2_stall", 4'd3, O_MRD);
    mem_ready = 1'b1;
    step("lw2_mrd", 4'd3, O_MRD);
    step("lw2_mwb", 4'd4, O_MWB);

    // FETCH stalls two cycles, then an illegal opcode traps
    mem_ready = 1'b0;
    step("f_stall0", 4'd0, O_FST);
    step("f_stall1", 4'd0, O_FST);
    mem_ready = 1'b1;
    step("f_go", 4'd0, O_FGO);
    opcode = OP_BAD;
    step("bad_dec", 4'd1, O_DEC);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode = (i[1]) ? OP_LW : OP_R;
      step("trap_sticky", 4'd12, O_TRAP);
    end

    reset_n = 1'b0;
    #1;
    chk("trap_rst", 4'd0, O_ZERO);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    step("trap_rel", 4'd0, O_FGO);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d required finish before 20000", n_chk);
    $fatal(1, "timeout");
  end

endmodule
